// File: rtl/sr_pkg.sv
// Constants and types shared by the super-resolution output path:
// RGB888 field positions, frame geometry and the burst writer states.
package sr_pkg;

  localparam int unsigned FRAME_W = 640;
  localparam int unsigned FRAME_H = 480;

  // MSB of each 8-bit channel inside a {R,G,B} RGB888 word
  localparam int unsigned R_MSB = 23;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned B_MSB = 7;

  localparam int unsigned RGB888_W = 24;
  localparam int unsigned RGB565_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } wr_state_e;

endpackage

// File: rtl/rgb888_to_565.sv
// Registered RGB888 -> RGB565 pack stage; keeps the top R5/G6/B5 bits of each
// channel (plain truncation) and delays the valid flag to match.
module rgb888_to_565
  import sr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RGB888_W-1:0] din,
  input  logic                din_valid,
  output logic [RGB565_W-1:0] dout,
  output logic                dout_valid
);

  // Low channel bits are dropped by design.
  logic unused_lsbs;
  assign unused_lsbs = ^{din[R_MSB-5:G_MSB+1], din[G_MSB-6:B_MSB+1], din[B_MSB-5:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        dout <= {din[R_MSB -: 5], din[G_MSB -: 6], din[B_MSB -: 5]};
      end
    end
  end

endmodule

// File: rtl/pixel_burst_writer.sv
// Drains the RGB888 output FIFO in fixed-length bursts and pushes RGB565
// pixels to the SDRAM frame-buffer write port with per-frame address wrap.
module pixel_burst_writer
  import sr_pkg::*;
#(
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned FRAME_PIXELS = FRAME_W * FRAME_H,
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned CNT_WIDTH    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_WIDTH-1:0]  data_count_r,
  input  logic [23:0]           din,
  output logic                  rd_fifo,
  input  logic                  frame_start,
  output logic                  wr_req,
  input  logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_valid,
  output logic [15:0]           wr_data,
  output logic                  burst_done,
  output logic                  frame_done
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned SUM_W  = ADDR_WIDTH + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  // DRAIN lasts two cycles: FIFO read latency plus the pack register
  localparam logic [BEAT_W-1:0] DRAIN_LAST = BEAT_W'(1);

  wr_state_e             state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BEAT_W-1:0]     beat;
  logic                  restart_pend;
  logic                  din_valid;
  logic [SUM_W-1:0]      addr_sum;
  logic                  frame_wrap;
  logic                  burst_ready;

  assign addr_sum    = SUM_W'(addr) + SUM_W'(BURST_LEN);
  assign frame_wrap  = (addr_sum == SUM_W'(FRAME_PIXELS));
  assign burst_ready = (data_count_r >= CNT_WIDTH'(BURST_LEN));

  // FIFO read data is valid one cycle after the pop strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_valid <= 1'b0;
    end else begin
      din_valid <= rd_fifo;
    end
  end

  rgb888_to_565 u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (wr_data),
    .dout_valid (wr_valid)
  );

  // Burst sequencer: request, pop BURST_LEN pixels, drain the pipeline, advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      beat         <= '0;
      restart_pend <= 1'b0;
      wr_req       <= 1'b0;
      wr_addr      <= '0;
      rd_fifo      <= 1'b0;
      burst_done   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            addr <= '0;
          end
          if (burst_ready) begin
            wr_req  <= 1'b1;
            wr_addr <= frame_start ? '0 : addr;
            state   <= REQ;
          end
        end
        REQ: begin
          if (frame_start) begin
            restart_pend <= 1'b1;
          end
          if (wr_ack) begin
            wr_req  <= 1'b0;
            rd_fifo <= 1'b1;
            beat    <= '0;
            state   <= BURST;
          end
        end
        BURST: begin
          if (frame_start) begin
            restart_pend <= 1'b1;
          end
          if (beat == LAST_BEAT) begin
            rd_fifo <= 1'b0;
            beat    <= '0;
            state   <= DRAIN;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        DRAIN: begin
          if (frame_start) begin
            restart_pend <= 1'b1;
          end
          if (beat == DRAIN_LAST) begin
            burst_done   <= 1'b1;
            frame_done   <= frame_wrap;
            addr         <= (frame_wrap || restart_pend || frame_start)
                            ? '0 : addr_sum[ADDR_WIDTH-1:0];
            restart_pend <= 1'b0;
            beat         <= '0;
            state        <= IDLE;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
